tdm_mux8_tx: RTL and testbench

- Transmit-side companion to the 1-to-8 demux: collects single-bit data from 8 source lanes and serializes them onto one (data, sel) stream.
- The sel tag is the 3-bit lane index, so a downstream demux can route each bit back to its lane.
- Per-lane one-entry holding buffer, round-robin arbitration, valid/ready output handshake, sticky per-lane overflow flags.

---
 rtl/tdm_mux8_tx.sv | 155 +++++++++++++++
 tb/tb_tdm_mux8_tx.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_mux8_tx.sv
// tdm_mux8_tx: collects single-bit data from N = 2**SEL_W source lanes and
// serializes it onto one (out_data, out_sel) stream with a valid/ready
// handshake. Each lane has a one-entry holding buffer. Strobes that arrive
// while a lane is still full are dropped and flagged in a sticky ovf bit.
// Optional feature: define TDM_MUX8_TX_OVF_CNT_EN to add an 8-bit saturating
// count of dropped strobes (ovf_cnt).

module tdm_mux8_tx #(
    parameter int SEL_W = 3,
    parameter int RR_EN = 1,
    localparam int N = 2 ** SEL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     lane_vld,
    input  logic [N-1:0]     lane_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_data,
    output logic [SEL_W-1:0] out_sel,
    output logic [N-1:0]     ovf,
    input  logic             ovf_clr,
`ifdef TDM_MUX8_TX_OVF_CNT_EN
    output logic [7:0]       ovf_cnt,
`endif
    output logic             busy
);

    // Sum width for the drop counter: wide enough for 255 plus a full-lane drop.
    localparam int SUM_W = ((SEL_W + 2) > 9) ? (SEL_W + 2) : 9;

    logic [N-1:0]     pending;
    logic [N-1:0]     hold;
    logic [SEL_W-1:0] ptr;

    logic             out_free;
    logic             grant_found;
    logic [SEL_W-1:0] grant_idx;
    logic [SEL_W-1:0] cand;
    logic             load;
    logic [N-1:0]     grant_vec;
    logic [N-1:0]     capture;
    logic [N-1:0]     drop;

    // The output slot can take a new bit when it is empty or being emptied this edge.
    assign out_free = !out_valid || out_ready;
    assign load     = out_free && grant_found;
    assign busy     = (|pending) || out_valid;

    // Arbiter: round-robin search from ptr upward (wrapping), or lowest index first.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < N; k++) begin
            if (RR_EN != 0) begin
                cand = ptr + SEL_W'(k);
            end else begin
                cand = SEL_W'(k);
            end
            if (!grant_found && pending[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // One-hot of the lane being drained this edge, plus capture/drop decisions.
    always_comb begin
        grant_vec = '0;
        if (load) begin
            grant_vec[grant_idx] = 1'b1;
        end
        capture = lane_vld & (~pending | grant_vec);
        drop    = lane_vld & pending & ~grant_vec;
    end

    // Per-lane holding buffers; a granted lane may be refilled on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            hold    <= '0;
        end else begin
            pending <= (pending & ~grant_vec) | capture;
            hold    <= (hold & ~capture) | (lane_data & capture);
        end
    end

    // Output register: load the granted lane when free, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= 1'b0;
            out_sel   <= '0;
        end else if (out_free) begin
            if (grant_found) begin
                out_valid <= 1'b1;
                out_data  <= hold[grant_idx];
                out_sel   <= grant_idx;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    // Round-robin pointer moves past the winner, only when a load happens.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (load) begin
            ptr <= grant_idx + SEL_W'(1);
        end
    end

    // Sticky overflow flags; a new drop wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= '0;
        end else begin
            ovf <= (ovf & {N{~ovf_clr}}) | drop;
        end
    end

`ifdef TDM_MUX8_TX_OVF_CNT_EN
    logic [SEL_W:0] drop_cnt;
    logic [SUM_W-1:0] cnt_sum;
    logic [7:0]     cnt_base;
    logic [7:0]     cnt_nxt;

    // Count the drops of this edge and add them to the (possibly cleared) total.
    always_comb begin
        drop_cnt = '0;
        for (int i = 0; i < N; i++) begin
            drop_cnt = drop_cnt + {{SEL_W{1'b0}}, drop[i]};
        end
        cnt_base = ovf_clr ? 8'd0 : ovf_cnt;
        cnt_sum  = SUM_W'(cnt_base) + SUM_W'(drop_cnt);
        if (cnt_sum > SUM_W'(255)) begin
            cnt_nxt = 8'hFF;
        end else begin
            cnt_nxt = cnt_sum[7:0];
        end
    end

    // Saturating dropped-strobe counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt <= 8'd0;
        end else begin
            ovf_cnt <= cnt_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_tdm_mux8_tx.sv
// tb_tdm_mux8_tx: self-checking bench for tdm_mux8_tx. Runs a round-robin
// instance and a fixed-priority instance; transfers of the round-robin
// instance are checked against a queue of expected {sel, data} pairs.

module tb_tdm_mux8_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] lane_vld = '0;
    logic [7:0] lane_vld_fp = '0;
    logic [7:0] lane_data = '0;
    logic       out_ready = 1'b0;
    logic       ovf_clr = 1'b0;

    logic       out_valid, out_data, busy;
    logic [2:0] out_sel;
    logic [7:0] ovf;
    logic       out_valid_fp, out_data_fp, busy_fp;
    logic [2:0] out_sel_fp;
    logic [7:0] ovf_fp;
`ifdef TDM_MUX8_TX_OVF_CNT_EN
    logic [7:0] ovf_cnt, ovf_cnt_fp;
`endif

    int n_checks = 0;
    int n_fails  = 0;
    logic [3:0] sb[$];

    typedef struct {
        logic [7:0] vld;
        logic [7:0] data;
        logic       ready;
        logic       exp_valid;
        logic [2:0] exp_sel;
        logic       exp_data;
        logic       exp_busy;
    } vec_t;

    vec_t tbl[10];

    tdm_mux8_tx #(.SEL_W(3), .RR_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .lane_vld(lane_vld), .lane_data(lane_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sel(out_sel), .ovf(ovf), .ovf_clr(ovf_clr),
`ifdef TDM_MUX8_TX_OVF_CNT_EN
        .ovf_cnt(ovf_cnt),
`endif
        .busy(busy)
    );

    tdm_mux8_tx #(.SEL_W(3), .RR_EN(0)) dut_fp (
        .clk(clk), .rst_n(rst_n), .lane_vld(lane_vld_fp), .lane_data(lane_data),
        .out_valid(out_valid_fp), .out_ready(out_ready), .out_data(out_data_fp),
        .out_sel(out_sel_fp), .ovf(ovf_fp), .ovf_clr(ovf_clr),
`ifdef TDM_MUX8_TX_OVF_CNT_EN
        .ovf_cnt(ovf_cnt_fp),
`endif
        .busy(busy_fp)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] vld, input logic [7:0] data, input logic ready, input logic clr);
        lane_vld  = vld;
        lane_data = data;
        out_ready = ready;
        ovf_clr   = clr;
    endtask

    // Score any handshake about to happen, then advance one edge and settle.
    task automatic tick();
        logic [3:0] exp;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checkOutput("sb_unexpected_transfer", {28'd0, out_sel, out_data}, 32'hFFFF_FFFF);
            end else begin
                exp = sb.pop_front();
                checkOutput("sb_sel", {29'd0, out_sel}, {29'd0, exp[3:1]});
                checkOutput("sb_data", {31'd0, out_data}, {31'd0, exp[0]});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        applyStimulus(8'h00, 8'h00, 1'b0, 1'b0);
        lane_vld_fp = 8'h00;
        sb.delete();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        // Cycle-by-cycle expectations for the full 8-lane drain of data 0x5A.
        tbl[0] = '{8'hFF, 8'h5A, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1};
        tbl[1] = '{8'h00, 8'h00, 1'b1, 1'b1, 3'd0, 1'b0, 1'b1};
        tbl[2] = '{8'h00, 8'h00, 1'b1, 1'b1, 3'd1, 1'b1, 1'b1};
        tbl[3] = '{8'h00, 8'h00, 1'b1, 1'b1, 3'd2, 1'b0, 1'b1};
        tbl[4] = '{8'h00, 8'h00, 1'b1, 1'b1, 3'd3, 1'b1, 1'b1};
        tbl[5] = '{8'h00, 8'h00, 1'b1, 1'b1, 3'd4, 1'b1, 1'b1};
        tbl[6] = '{8'h00, 8'h00, 1'b1, 1'b1, 3'd5, 1'b0, 1'b1};
        tbl[7] = '{8'h00, 8'h00, 1'b1, 1'b1, 3'd6, 1'b1, 1'b1};
        tbl[8] = '{8'h00, 8'h00, 1'b1, 1'b1, 3'd7, 1'b0, 1'b1};
        tbl[9] = '{8'h00, 8'h00, 1'b1, 1'b0, 3'd7, 1'b0, 1'b0};

        // Reset with all lanes strobing, then release with inputs held.
        $display("[TB] reset test");
        rst_n = 1'b0;
        applyStimulus(8'hFF, 8'hA5, 1'b0, 1'b0);
        #1;
        tick();
        tick();
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_out_data", {31'd0, out_data}, 32'd0);
        checkOutput("rst_out_sel", {29'd0, out_sel}, 32'd0);
        checkOutput("rst_ovf", {24'd0, ovf}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
`ifdef TDM_MUX8_TX_OVF_CNT_EN
        checkOutput("rst_ovf_cnt", {24'd0, ovf_cnt}, 32'd0);
`endif
        rst_n = 1'b1;
        tick();
        checkOutput("rel_e0_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rel_e0_busy", {31'd0, busy}, 32'd1);
        tick();
        checkOutput("rel_e1_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("rel_e1_sel", {29'd0, out_sel}, 32'd0);
        checkOutput("rel_e1_data", {31'd0, out_data}, 32'd1);
        checkOutput("rel_e1_ovf", {24'd0, ovf}, 32'hFE);

        // Table-driven drain of all eight lanes with the sink always ready.
        $display("[TB] round-robin drain test");
        do_reset();
        for (int i = 0; i < 8; i++) begin
            sb.push_back({3'(i), tbl[i+1].exp_data});
        end
        for (int r = 0; r < 10; r++) begin
            applyStimulus(tbl[r].vld, tbl[r].data, tbl[r].ready, 1'b0);
            tick();
            checkOutput($sformatf("tbl%0d_valid", r), {31'd0, out_valid}, {31'd0, tbl[r].exp_valid});
            checkOutput($sformatf("tbl%0d_sel", r), {29'd0, out_sel}, {29'd0, tbl[r].exp_sel});
            checkOutput($sformatf("tbl%0d_data", r), {31'd0, out_data}, {31'd0, tbl[r].exp_data});
            checkOutput($sformatf("tbl%0d_busy", r), {31'd0, busy}, {31'd0, tbl[r].exp_busy});
        end
        checkOutput("drain_sb_empty", 32'(sb.size()), 32'd0);

        // Back-pressure: output stable, recapture during hold, then overflow.
        $display("[TB] hold test");
        do_reset();
        applyStimulus(8'h08, 8'h08, 1'b0, 1'b0);
        tick();
        applyStimulus(8'h00, 8'h00, 1'b0, 1'b0);
        tick();
        sb.push_back({3'd3, 1'b1});
        checkOutput("hold_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("hold_sel", {29'd0, out_sel}, 32'd3);
        checkOutput("hold_data", {31'd0, out_data}, 32'd1);
        applyStimulus(8'h08, 8'h00, 1'b0, 1'b0);
        tick();
        sb.push_back({3'd3, 1'b0});
        checkOutput("hold_cap_ovf", {24'd0, ovf}, 32'd0);
        applyStimulus(8'h08, 8'h08, 1'b0, 1'b0);
        tick();
        checkOutput("hold_drop_ovf", {24'd0, ovf}, 32'h08);
        applyStimulus(8'h00, 8'h00, 1'b0, 1'b0);
        for (int c = 0; c < 2; c++) begin
            tick();
            checkOutput($sformatf("hold_stable_sel%0d", c), {29'd0, out_sel}, 32'd3);
            checkOutput($sformatf("hold_stable_data%0d", c), {31'd0, out_data}, 32'd1);
            checkOutput($sformatf("hold_stable_valid%0d", c), {31'd0, out_valid}, 32'd1);
        end
        applyStimulus(8'h00, 8'h00, 1'b1, 1'b0);
        tick();
        tick();
        checkOutput("hold_end_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("hold_sb_empty", 32'(sb.size()), 32'd0);
        checkOutput("hold_ovf_sticky", {24'd0, ovf}, 32'h08);

        // Lanes 2 and 6: round-robin alternates, fixed priority starves lane 6.
        $display("[TB] arbitration test");
        do_reset();
        sb.push_back({3'd2, 1'b1});
        sb.push_back({3'd6, 1'b0});
        sb.push_back({3'd2, 1'b1});
        sb.push_back({3'd6, 1'b0});
        lane_vld_fp = 8'h44;
        applyStimulus(8'h44, 8'h04, 1'b1, 1'b0);
        tick();
        checkOutput("fp_e0_ovf", {24'd0, ovf_fp}, 32'd0);
        applyStimulus(8'h04, 8'h04, 1'b1, 1'b0);
        tick();
        checkOutput("rr_e1_sel", {29'd0, out_sel}, 32'd2);
        checkOutput("fp_e1_sel", {29'd0, out_sel_fp}, 32'd2);
        checkOutput("fp_e1_data", {31'd0, out_data_fp}, 32'd1);
        checkOutput("fp_e1_ovf", {24'd0, ovf_fp}, 32'h40);
        applyStimulus(8'h40, 8'h04, 1'b1, 1'b0);
        tick();
        checkOutput("rr_e2_sel", {29'd0, out_sel}, 32'd6);
        checkOutput("fp_e2_sel", {29'd0, out_sel_fp}, 32'd2);
        applyStimulus(8'h00, 8'h04, 1'b1, 1'b0);
        tick();
        checkOutput("rr_e3_sel", {29'd0, out_sel}, 32'd2);
        checkOutput("fp_e3_sel", {29'd0, out_sel_fp}, 32'd2);
        tick();
        checkOutput("rr_e4_sel", {29'd0, out_sel}, 32'd6);
        checkOutput("fp_e4_sel", {29'd0, out_sel_fp}, 32'd2);
        checkOutput("fp_e4_valid", {31'd0, out_valid_fp}, 32'd1);
        checkOutput("fp_e4_busy", {31'd0, busy_fp}, 32'd1);
        checkOutput("rr_ovf", {24'd0, ovf}, 32'd0);
        lane_vld_fp = 8'h00;
        tick();
        checkOutput("rr_sb_empty", 32'(sb.size()), 32'd0);
        checkOutput("rr_end_valid", {31'd0, out_valid}, 32'd0);

        // Overflow on lane 5 coinciding with ovf_clr, then a lone clear.
        $display("[TB] overflow clear test");
        do_reset();
        applyStimulus(8'h22, 8'h00, 1'b0, 1'b0);
        tick();
        applyStimulus(8'h00, 8'h00, 1'b0, 1'b0);
        tick();
        applyStimulus(8'h20, 8'h00, 1'b0, 1'b0);
        tick();
        checkOutput("clr_pre_ovf", {24'd0, ovf}, 32'h20);
`ifdef TDM_MUX8_TX_OVF_CNT_EN
        checkOutput("clr_pre_cnt", {24'd0, ovf_cnt}, 32'd1);
`endif
        applyStimulus(8'h20, 8'h00, 1'b0, 1'b1);
        tick();
        checkOutput("clr_set_wins_ovf", {24'd0, ovf}, 32'h20);
`ifdef TDM_MUX8_TX_OVF_CNT_EN
        checkOutput("clr_set_wins_cnt", {24'd0, ovf_cnt}, 32'd1);
`endif
        applyStimulus(8'h00, 8'h00, 1'b0, 1'b1);
        tick();
        checkOutput("clr_alone_ovf", {24'd0, ovf}, 32'd0);
`ifdef TDM_MUX8_TX_OVF_CNT_EN
        checkOutput("clr_alone_cnt", {24'd0, ovf_cnt}, 32'd0);
`endif

        // Long overflow burst on lane 1, then an asynchronous reset mid-burst.
        $display("[TB] saturation and mid-burst reset test");
        do_reset();
        applyStimulus(8'h02, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 302; i++) begin
            tick();
`ifdef TDM_MUX8_TX_OVF_CNT_EN
            if (i == 255) begin
                checkOutput("cnt_254", {24'd0, ovf_cnt}, 32'd254);
            end
`endif
        end
        checkOutput("burst_ovf", {24'd0, ovf}, 32'h02);
        checkOutput("burst_valid", {31'd0, out_valid}, 32'd1);
`ifdef TDM_MUX8_TX_OVF_CNT_EN
        checkOutput("cnt_saturated", {24'd0, ovf_cnt}, 32'd255);
`endif
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("midrst_ovf", {24'd0, ovf}, 32'd0);
        checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
`ifdef TDM_MUX8_TX_OVF_CNT_EN
        checkOutput("midrst_cnt", {24'd0, ovf_cnt}, 32'd0);
`endif
        applyStimulus(8'h00, 8'h00, 1'b0, 1'b0);
        sb.delete();
        tick();
        rst_n = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
